// File: rtl/jc_pkg.sv
// Shared types and helpers for the Johnson-counter phase tracker and the counter's bench checker.
package jc_pkg;

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StTrack    = 2'd1,
    StLocked   = 2'd2
  } jc_state_e;

  typedef struct packed {
    logic       legal;
    logic [7:0] phase;
  } jc_dec_t;

  function automatic int unsigned phase_w(input int unsigned n);
    return (2 * n <= 2) ? 1 : $clog2(2 * n);
  endfunction

  // Code bits at and above n must be zero; supports n up to 31.
  function automatic jc_dec_t jc_decode(input logic [31:0] code, input int unsigned n);
    jc_dec_t     r;
    logic [31:0] mask;
    logic [31:0] ones;
    r    = '0;
    mask = (32'd1 << n) - 32'd1;
    for (int unsigned k = 0; k < 32; k++) begin
      ones = (32'd1 << k) - 32'd1;
      if (k <= n && code == ones) begin
        r.legal = 1'b1;
        r.phase = 8'(k);
      end
      if (k >= 1 && k < n && code == (~ones & mask)) begin
        r.legal = 1'b1;
        r.phase = 8'(n + k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/jc_phase_tracker_if.sv
// Counter-sample input and tracker status bundle; master drives samples, slave is the tracker.
interface jc_phase_tracker_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned ERR_W = 8
);
  localparam int unsigned PW = jc_pkg::phase_w(N);

  logic [N-1:0]     q;
  logic             q_vld;
  logic [PW-1:0]    phase;
  logic             phase_vld;
  logic             wrap;
  logic             illegal;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output q, q_vld,
    input  phase, phase_vld, wrap, illegal, locked, err_cnt
  );

  modport slave (
    input  q, q_vld,
    output phase, phase_vld, wrap, illegal, locked, err_cnt
  );
endinterface

// File: rtl/jc_code_decode.sv
// Combinational Johnson-word validator: flags legality and returns the phase index.
module jc_code_decode
  import jc_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 3
) (
  input  logic [N-1:0]  q_i,
  output logic          legal_o,
  output logic [PW-1:0] phase_o
);
  jc_dec_t dec;

  always_comb begin
    dec     = jc_decode(32'(q_i), N);
    legal_o = dec.legal;
    phase_o = PW'(dec.phase);
  end
endmodule

// File: rtl/jc_phase_tracker.sv
// Johnson-counter phase tracker: decode, sequence check, lock FSM, wrap strobe, lock-loss count.
// Define JC_PHASE_TRACKER_FLYWHEEL_EN to ride through a single bad sample while locked.
module jc_phase_tracker
  import jc_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input logic               clk,
  input logic               clr,
  jc_phase_tracker_if.slave bus
);
  localparam int unsigned    PW        = phase_w(N);
  localparam logic [PW-1:0]  LastPhase = PW'(2 * N - 1);

  jc_state_e        state_q, state_d;
  logic [3:0]       good_q, good_d;
  logic [PW-1:0]    ref_q, ref_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             phase_vld_q, phase_vld_d;
  logic             wrap_q, wrap_d;
  logic             illegal_q, illegal_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             err_inc;
`ifdef JC_PHASE_TRACKER_FLYWHEEL_EN
  logic             miss_q, miss_d;
`endif

  logic          legal;
  logic [PW-1:0] dec_phase;
  logic [PW-1:0] next_ref;
  logic          in_seq;

  jc_code_decode #(
    .N  (N),
    .PW (PW)
  ) u_decode (
    .q_i     (bus.q),
    .legal_o (legal),
    .phase_o (dec_phase)
  );

  assign next_ref = (ref_q == LastPhase) ? '0 : ref_q + PW'(1);
  assign in_seq   = legal && (dec_phase == next_ref);

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    ref_d       = ref_q;
    phase_d     = phase_q;
    phase_vld_d = 1'b0;
    wrap_d      = 1'b0;
    illegal_d   = 1'b0;
    err_inc     = 1'b0;
`ifdef JC_PHASE_TRACKER_FLYWHEEL_EN
    miss_d      = miss_q;
`endif
    if (bus.q_vld) begin
      if (legal) begin
        ref_d       = dec_phase;
        phase_d     = dec_phase;
        phase_vld_d = 1'b1;
      end else begin
        illegal_d = 1'b1;
      end
      unique case (state_q)
        StUnlocked: begin
          if (legal) begin
            state_d = StTrack;
            good_d  = 4'd1;
          end
        end
        StTrack: begin
          if (in_seq) begin
            good_d = good_q + 4'd1;
            if (({1'b0, good_q} + 5'd1) >= 5'(LOCK_CNT)) state_d = StLocked;
          end else if (legal) begin
            good_d = 4'd1;
          end else begin
            state_d = StUnlocked;
            good_d  = 4'd0;
          end
        end
        StLocked: begin
          if (in_seq) begin
            wrap_d = (ref_q == LastPhase);
`ifdef JC_PHASE_TRACKER_FLYWHEEL_EN
            miss_d = 1'b0;
`endif
          end else begin
`ifdef JC_PHASE_TRACKER_FLYWHEEL_EN
            if (!miss_q) begin
              // Coast on the predicted phase; the lock loss is still counted once.
              miss_d      = 1'b1;
              ref_d       = next_ref;
              phase_d     = next_ref;
              phase_vld_d = 1'b1;
              err_inc     = 1'b1;
            end else begin
              miss_d  = 1'b0;
              state_d = legal ? StTrack : StUnlocked;
              good_d  = legal ? 4'd1 : 4'd0;
            end
`else
            err_inc = 1'b1;
            state_d = legal ? StTrack : StUnlocked;
            good_d  = legal ? 4'd1 : 4'd0;
`endif
          end
        end
        default: begin
          state_d = StUnlocked;
          good_d  = 4'd0;
        end
      endcase
    end
    err_d = (err_inc && err_q != '1) ? err_q + ERR_W'(1) : err_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StUnlocked;
      good_q      <= 4'd0;
      ref_q       <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      wrap_q      <= 1'b0;
      illegal_q   <= 1'b0;
      err_q       <= '0;
`ifdef JC_PHASE_TRACKER_FLYWHEEL_EN
      miss_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      ref_q       <= ref_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      wrap_q      <= wrap_d;
      illegal_q   <= illegal_d;
      err_q       <= err_d;
`ifdef JC_PHASE_TRACKER_FLYWHEEL_EN
      miss_q      <= miss_d;
`endif
    end
  end

  assign bus.phase     = phase_q;
  assign bus.phase_vld = phase_vld_q;
  assign bus.wrap      = wrap_q;
  assign bus.illegal   = illegal_q;
  assign bus.locked    = (state_q == StLocked);
  assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_jc_phase_tracker.sv
// Directed and randomized bench for jc_phase_tracker against a phase-level behavioural model.
module tb_jc_phase_tracker;
  localparam int N        = 4;
  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int NP       = 2 * N;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  jc_phase_tracker_if #(.N(N), .ERR_W(ERR_W)) bus ();

  jc_phase_tracker #(
    .N        (N),
    .LOCK_CNT (LOCK_CNT),
    .ERR_W    (ERR_W)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model state, expressed as "locked / tracking with a run length" rather than an encoded FSM.
  int m_phase, m_ref, m_run, m_err;
  bit m_locked, m_tracking, m_miss;
  bit e_pv, e_wrap, e_ill;
  int pos;

  function automatic logic [N-1:0] code_of(input int p);
    logic [N-1:0] c;
    c = '0;
    for (int b = 0; b < N; b++) begin
      if (p <= N) c[b] = (b < p);
      else        c[b] = (b >= p - N);
    end
    return c;
  endfunction

  function automatic int index_of(input logic [N-1:0] c);
    for (int p = 0; p < NP; p++) if (code_of(p) == c) return p;
    return -1;
  endfunction

  function automatic logic [N-1:0] bad_code();
    logic [N-1:0] c;
    for (int t = 0; t < 64; t++) begin
      c = N'($urandom);
      if (index_of(c) < 0) return c;
    end
    c = 4'b0101;
    return c;
  endfunction

  task automatic reset_model();
    m_phase = 0; m_ref = 0; m_run = 0; m_err = 0;
    m_locked = 0; m_tracking = 0; m_miss = 0;
    e_pv = 0; e_wrap = 0; e_ill = 0;
  endtask

  task automatic model_step(input logic [N-1:0] c, input logic v);
    int idx;
    bit inseq, coast;
    e_pv = 0; e_wrap = 0; e_ill = 0;
    if (!v) return;
    idx   = index_of(c);
    inseq = (idx >= 0) && (idx == (m_ref + 1) % NP);
    coast = 0;
    if (idx < 0) e_ill = 1;
    if (m_locked) begin
      if (inseq) begin
        e_wrap = (idx == 0);
        m_miss = 0;
      end else begin
`ifdef JC_PHASE_TRACKER_FLYWHEEL_EN
        if (!m_miss) begin
          coast   = 1;
          m_miss  = 1;
          m_err   = (m_err < ERR_MAX) ? m_err + 1 : m_err;
          m_ref   = (m_ref + 1) % NP;
          m_phase = m_ref;
          e_pv    = 1;
        end else begin
          m_miss = 0;
        end
`else
        m_err = (m_err < ERR_MAX) ? m_err + 1 : m_err;
`endif
        if (!coast) begin
          m_locked   = 0;
          m_tracking = (idx >= 0);
          m_run      = (idx >= 0) ? 1 : 0;
        end
      end
    end else if (m_tracking) begin
      if (inseq) begin
        m_run++;
        if (m_run >= LOCK_CNT) begin
          m_locked   = 1;
          m_tracking = 0;
        end
      end else if (idx >= 0) begin
        m_run = 1;
      end else begin
        m_tracking = 0;
        m_run      = 0;
      end
    end else if (idx >= 0) begin
      m_tracking = 1;
      m_run      = 1;
    end
    if (idx >= 0 && !coast) begin
      m_ref   = idx;
      m_phase = idx;
      e_pv    = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, "/phase"},     32'(bus.phase),     32'(m_phase));
    chk({where, "/phase_vld"}, 32'(bus.phase_vld), 32'(e_pv));
    chk({where, "/wrap"},      32'(bus.wrap),      32'(e_wrap));
    chk({where, "/illegal"},   32'(bus.illegal),   32'(e_ill));
    chk({where, "/locked"},    32'(bus.locked),    32'(m_locked));
    chk({where, "/err_cnt"},   32'(bus.err_cnt),   32'(m_err));
  endtask

  task automatic drive(input logic [N-1:0] c, input logic v, input string where);
    bus.q     = c;
    bus.q_vld = v;
    @(posedge clk);
    model_step(c, v);
    #1;
    check_outputs(where);
  endtask

  task automatic next_code(input string where);
    drive(code_of(pos), 1'b1, where);
    pos = (pos + 1) % NP;
  endtask

  initial begin
    int r;
    clr       = 1'b0;
    bus.q     = '0;
    bus.q_vld = 1'b0;
    reset_model();
    #12;
    check_outputs("reset");
    @(negedge clk);
    clr = 1'b1;
    pos = 0;

    // Clean Johnson sequence from 0000: lock and wrap strobes.
    for (int i = 0; i < 20; i++) next_code("seq");

    // Illegal word while locked; the corrupted sample replaced one real code.
    drive(4'b0101, 1'b1, "inject_illegal");
    pos = (pos + 1) % NP;
    for (int i = 0; i < 10; i++) next_code("resume");

    // Out-of-sequence jump to phase 6 while locked at phase 2.
    for (int i = 0; i < 40 && !(m_locked && m_phase == 2); i++) next_code("to_phase2");
    chk("at_phase2_locked", 32'(bus.locked), 32'd1);
    drive(code_of(6), 1'b1, "jump_phase6");
    pos = 7;
    for (int i = 0; i < 10; i++) next_code("after_jump");

    // q_vld gap of three cycles mid-sequence.
    for (int i = 0; i < 3; i++) drive(N'($urandom), 1'b0, "gap");
    for (int i = 0; i < 6; i++) next_code("after_gap");

    // Repeated lock losses drive the error counter into saturation.
    for (int i = 0; i < 300; i++) begin
      drive(bad_code(), 1'b1, "loss_a");
      drive(bad_code(), 1'b1, "loss_b");
      for (int j = 0; j < LOCK_CNT; j++) next_code("relock");
    end
    chk("err_saturated", 32'(bus.err_cnt), 32'(ERR_MAX));

    // Randomized mix of clean steps, jumps, illegal words and idle cycles.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) drive(N'($urandom), 1'b0, "rnd_idle");
      else if (r == 1) drive(bad_code(), 1'b1, "rnd_illegal");
      else if (r == 2) begin
        pos = $urandom_range(0, NP - 1);
        next_code("rnd_jump");
      end else next_code("rnd_seq");
    end

    // Asynchronous clear between clock edges.
    for (int i = 0; i < 6; i++) next_code("pre_clr");
    #3;
    clr = 1'b0;
    #1;
    chk("clr/phase",     32'(bus.phase),     32'd0);
    chk("clr/phase_vld", 32'(bus.phase_vld), 32'd0);
    chk("clr/wrap",      32'(bus.wrap),      32'd0);
    chk("clr/illegal",   32'(bus.illegal),   32'd0);
    chk("clr/locked",    32'(bus.locked),    32'd0);
    chk("clr/err_cnt",   32'(bus.err_cnt),   32'd0);
    reset_model();
    @(negedge clk);
    clr = 1'b1;
    pos = 0;
    for (int i = 0; i < 10; i++) next_code("post_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
